// File: rtl/eaf_pkg.sv
// Shared types and defaults for the EAF filter and its request scheduler.
// The scheduler and filter agree on address width and capacity here.
package eaf_pkg;

  localparam int unsigned EAF_ADDR_LENGTH = 32;
  localparam int unsigned EAF_MAX_ENTRIES = 16;

  typedef enum logic [1:0] {
    IDLE,
    TEST,
    INSERT,
    CLEAR
  } sched_state_e;

endpackage

// File: rtl/eaf_addr_fifo.sv
// Small synchronous FIFO holding evicted block addresses.
// Occupancy is tracked by a count register, pointers wrap naturally.
module eaf_addr_fifo #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       din,
  output logic [width-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int unsigned AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(depth);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  // A pop frees the slot a same-cycle push lands in
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/eaf_request_scheduler.sv
// Sole master of the EAF filter command port: arbitrates lookups
// against buffered eviction inserts and clears the filter when full.
module eaf_request_scheduler
  import eaf_pkg::*;
#(
  parameter int unsigned addr_length        = EAF_ADDR_LENGTH,
  parameter int unsigned ins_fifo_depth     = 4,
  parameter int unsigned max_num_of_entries = EAF_MAX_ENTRIES,
  parameter int unsigned starve_limit       = 3,
  parameter int unsigned cmd_timeout        = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   test_req_i,
  input  logic [addr_length-1:0] test_addr_i,
  output logic                   test_gnt_o,
  output logic                   test_done_o,
  output logic                   test_hit_o,
  input  logic                   ins_valid_i,
  input  logic [addr_length-1:0] ins_addr_i,
  output logic                   ins_ready_o,
  output logic [addr_length-1:0] filt_addr_o,
  output logic                   filt_test_o,
  output logic                   filt_insert_o,
  output logic                   filt_clear_o,
  input  logic                   filt_resp_i,
  input  logic                   filt_exists_i,
  output logic [$clog2(max_num_of_entries+1)-1:0] fill_count_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int unsigned FW = $clog2(max_num_of_entries + 1);
  localparam int unsigned CW = $clog2(cmd_timeout + 1);
  localparam int unsigned SW = $clog2(starve_limit + 1);
  localparam int unsigned QW = $clog2(ins_fifo_depth) + 1;

  sched_state_e           state_q;
  logic [addr_length-1:0] addr_q;
  logic [addr_length-1:0] head;
  logic [FW-1:0]          fill_q;
  logic [CW-1:0]          cnt_q;
  logic [SW-1:0]          starve_q;
  logic [QW-1:0]          fifo_cnt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   go_test;
  logic                   go_ins;
  logic                   go_clr;
  logic                   test_cmd_q;
  logic                   ins_cmd_q;
  logic                   clr_cmd_q;
  logic                   hit_q;
  logic                   tmo_q;
  logic                   at_cap;
  logic                   expire;
  logic                   finish;

  assign ins_ready_o = rst & ~fifo_full;
  assign push        = ins_valid_i & ins_ready_o;

  eaf_addr_fifo #(
    .width (addr_length),
    .depth (ins_fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (go_ins),
    .din   (ins_addr_i),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign at_cap = fill_q == FW'(max_num_of_entries);
  assign expire = (state_q != IDLE) && !filt_resp_i
                && (cnt_q == CW'(cmd_timeout - 1));
  assign finish = (state_q != IDLE)
                && (filt_resp_i || expire);

  // Capacity clear first, then the starvation guard, then lookups
  always_comb begin
    go_test = 1'b0;
    go_ins  = 1'b0;
    go_clr  = 1'b0;
    if (rst && state_q == IDLE) begin
      if (at_cap)
        go_clr = 1'b1;
      else if (starve_q >= SW'(starve_limit) && !fifo_empty)
        go_ins = 1'b1;
      else if (test_req_i)
        go_test = 1'b1;
      else if (!fifo_empty)
        go_ins = 1'b1;
    end
  end

  assign test_gnt_o    = go_test;
  assign test_done_o   = rst && state_q == TEST && finish;
  assign test_hit_o    = test_done_o
                       ? (filt_resp_i & filt_exists_i)
                       : hit_q;
  assign filt_addr_o   = addr_q;
  assign filt_test_o   = test_cmd_q;
  assign filt_insert_o = ins_cmd_q;
  assign filt_clear_o  = clr_cmd_q;
  assign fill_count_o  = fill_q;
  assign busy_o        = state_q != IDLE;
  assign timeout_o     = tmo_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      test_cmd_q <= 1'b0;
      ins_cmd_q  <= 1'b0;
      clr_cmd_q  <= 1'b0;
      hit_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      test_cmd_q <= go_test;
      ins_cmd_q  <= go_ins;
      clr_cmd_q  <= go_clr;
      if (state_q == IDLE || finish)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CW'(1);
      if (expire) tmo_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (go_clr) begin
            state_q <= CLEAR;
          end else if (go_ins) begin
            state_q  <= INSERT;
            addr_q   <= head;
            starve_q <= '0;
          end else if (go_test) begin
            state_q  <= TEST;
            addr_q   <= test_addr_i;
            starve_q <= (fifo_cnt != '0)
                      ? starve_q + SW'(1) : '0;
          end
        end
        TEST: if (finish) begin
          state_q <= IDLE;
          hit_q   <= filt_resp_i & filt_exists_i;
        end
        INSERT: if (finish) begin
          state_q <= IDLE;
          if (filt_resp_i && !at_cap)
            fill_q <= fill_q + FW'(1);
        end
        CLEAR: if (finish) begin
          state_q <= IDLE;
          fill_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
